plic_claim_ctrl: RTL and testbench
==================================

# plic_claim_ctrl

Claim/complete sequencer for the platform interrupt controller's arbitration datapath. It runs the core's claim and complete accesses and keeps a LIFO of claimed interrupt IDs so nested, preempting interrupts unwind in order. The top-of-stack ID drives the arbiter's `claim_id`. The block emits one-cycle `cmplt_id` and pending-clear strobes back to the gate and pending registers. It sits between the register-file bus decoder and the arbitration core.

## Interface
Parameters:
- `EXT_IRQ_NUM`, 31, highest external interrupt ID; ID 0 means "none".
- `NEST_DEPTH`, 4, maximum simultaneously claimed IDs (stack entries), 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `final_id`  in  8  arbitration winner ID from the arbiter.
- `ext_irq`  in  1  winner exceeds threshold and the current claim priority.
- `claim_req`  in  1  core read of the claim register; held until `claim_ack`.
- `claim_ack`  out  1  one-cycle claim completion.
- `claim_rdata`  out  8  claimed ID, valid with `claim_ack`; 0 = nothing claimed.
- `cmplt_req`  in  1  core write of the complete register; held until `cmplt_ack`.
- `cmplt_wdata`  in  8  ID being completed.
- `cmplt_ack`  out  1  one-cycle completion acknowledge.
- `cmplt_err`  out  1  with `cmplt_ack`: ID mismatched top of stack; nothing popped.
- `claim_id`  out  8  top-of-stack ID, or 0 when the stack is empty.
- `cmplt_id`  out  8  completed ID, one-cycle pulse; 0 otherwise.
- `ip_clr`  out  EXT_IRQ_NUM+1  one-hot pending-clear pulse for the claimed ID.
- `nest_level`  out  4  current stack occupancy.
- `stack_full`  out  1  `nest_level == NEST_DEPTH`.

## Operation
- FSM states: IDLE, SETTLE, ACK. Reset goes to IDLE.
- IDLE:
  - `cmplt_req` → ACK, complete path.
  - Else `claim_req` → SETTLE.
  - Complete wins when both requests are high; the claim stays held and is served afterward.
- SETTLE: one cycle that lets the registered arbiter settle. At the end of it, sample `ext_irq` and `final_id`, then go to ACK.
  - Push only if `ext_irq && final_id != 0 && !stack_full`.
  - On push: `claim_rdata = final_id`, and `ip_clr[final_id] = 1` for one cycle.
  - Otherwise: `claim_rdata = 0`, no push, `ip_clr = 0`.
- Complete path, on leaving IDLE:
  - If the stack is not empty and `cmplt_wdata == claim_id`: pop, `cmplt_id = cmplt_wdata` for one cycle, `cmplt_err = 0`.
  - Else: no pop, `cmplt_id = 0`, `cmplt_err = 1`. This covers an empty stack, ID 0, and out-of-order completes.
- ACK: lasts one cycle with the relevant ack high, then IDLE unconditionally.
  - Requests are ignored in ACK.
  - The requester drops its request in the cycle it sees the ack.
- Stack:
  - Registered array of 8-bit entries plus a pointer.
  - Push and pop never happen in the same cycle.
  - Popping with the pointer at 0 is impossible by construction; the check is above.
- `claim_id`, `nest_level` and `stack_full` are registered and reflect the stack after the update.
- `cmplt_id` pulses only on a successful pop; the gate logic relies on that.

## Timing
- Reset values: every output is 0, the stack pointer is 0, and the FSM is in IDLE.
- Claim latency: `claim_req` sampled high at edge N gives `claim_ack`/`claim_rdata`/`ip_clr` high in cycle N+2 (after edge N+1 → SETTLE, edge N+2 → ACK). `claim_id` updates in the same cycle.
- Complete latency: `cmplt_req` sampled at edge N gives `cmplt_ack`/`cmplt_id`/`cmplt_err` in cycle N+1. `claim_id` shows the new top in the same cycle.
- Minimum spacing between back-to-back accesses: claim every 3 cycles, complete every 2.
- `rst` in SETTLE or ACK: the access is aborted, no push or pop is committed, no ack is issued, and the stack is emptied.
- `final_id` values above `EXT_IRQ_NUM` are treated as 0 (no push, rdata 0).

## Configuration
- `PLIC_CLAIM_NEST_EN` defined: the stack depth is `NEST_DEPTH`, and preemptive nesting is supported.
- Not defined: the effective depth is 1.
  - A claim while one ID is outstanding returns 0 with no push and no `ip_clr`.
  - `stack_full` equals `nest_level != 0`, and `NEST_DEPTH` is ignored.

## Test plan
- Reset, then `final_id=5`, `ext_irq=1`, `claim_req` → ack at N+2, `claim_rdata=5`, `ip_clr=1<<5`, `claim_id=5`, `nest_level=1`.
- Claim 5, then claim 9 (nested), then complete 9, then complete 5 → `cmplt_id` pulses 9 then 5, and `claim_id` goes 9 → 5 → 0.
- With 3 then 7 claimed, complete 3 → `cmplt_err=1`, `cmplt_id=0`, stack unchanged (`claim_id=7`, `nest_level=2`).
- Fill to `NEST_DEPTH=4`, then one more claim with `ext_irq=1`, `final_id=12` → `claim_rdata=0`, `ip_clr=0`, `nest_level` stays 4. Without the macro: second claim returns 0.
- `claim_req` and `cmplt_req(5)` in the same cycle with 5 on top → complete acked at N+1, claim acked at N+4.
- Assert `rst` during SETTLE → no ack, `claim_id=0`, `nest_level=0`, outputs 0 the next cycle.

Source files
------------

// File: rtl/plic_claim_ctrl_if.sv
// Core-side claim/complete register handshake for plic_claim_ctrl.
// The core (master) holds each request until it sees the matching one-cycle ack.
interface plic_claim_ctrl_if;
  logic       claim_req;
  logic       claim_ack;
  logic [7:0] claim_rdata;
  logic       cmplt_req;
  logic [7:0] cmplt_wdata;
  logic       cmplt_ack;
  logic       cmplt_err;

  modport master (
    output claim_req, cmplt_req, cmplt_wdata,
    input  claim_ack, claim_rdata, cmplt_ack, cmplt_err
  );

  modport slave (
    input  claim_req, cmplt_req, cmplt_wdata,
    output claim_ack, claim_rdata, cmplt_ack, cmplt_err
  );
endinterface

// File: rtl/plic_claim_ctrl.sv
// PLIC claim/complete sequencer with a LIFO of claimed IDs for nested interrupts.
// Define PLIC_CLAIM_NEST_EN for a NEST_DEPTH-deep stack; otherwise one claim may be outstanding.
module plic_claim_ctrl #(
  parameter int EXT_IRQ_NUM = 31,
  parameter int NEST_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  plic_claim_ctrl_if.slave       bus,
  input  logic [7:0]             final_id,
  input  logic                   ext_irq,
  output logic [7:0]             claim_id,
  output logic [7:0]             cmplt_id,
  output logic [EXT_IRQ_NUM:0]   ip_clr,
  output logic [3:0]             nest_level,
  output logic                   stack_full
);

`ifdef PLIC_CLAIM_NEST_EN
  localparam int DEPTH = NEST_DEPTH;
`else
  // Single-entry stack, never deeper than configured.
  localparam int DEPTH = (NEST_DEPTH > 1) ? 1 : NEST_DEPTH;
`endif

  localparam logic [7:0] ID_MAX  = 8'(EXT_IRQ_NUM);
  localparam logic [3:0] DEPTH_W = 4'(DEPTH);

  typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_t;

  state_t     state_reg, state_next;
  logic       op_claim_reg, op_claim_next;
  logic       claim_ack, cmplt_ack;

  logic [7:0] mem_reg [DEPTH];
  logic [3:0] sp_reg;
  logic [7:0] top_reg;
  logic       full_reg;
  logic [7:0] rdata_reg;
  logic [7:0] cmplt_id_reg;
  logic       err_reg;

  logic       id_ok, do_push, do_cmplt, do_pop;
  logic [7:0] below_top;

  assign id_ok    = (final_id != 8'd0) && (final_id <= ID_MAX);
  assign do_push  = (state_reg == SETTLE) && ext_irq && id_ok && !full_reg;
  assign do_cmplt = (state_reg == IDLE) && bus.cmplt_req;
  assign do_pop   = do_cmplt && (sp_reg != 4'd0) && (bus.cmplt_wdata == top_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_claim_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_claim_reg <= op_claim_next;
    end
  end

  // Complete has priority; a held claim is picked up on the next IDLE cycle.
  always_comb begin
    state_next    = state_reg;
    op_claim_next = op_claim_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmplt_req) begin
          state_next    = ACK;
          op_claim_next = 1'b0;
        end else if (bus.claim_req) begin
          state_next    = SETTLE;
          op_claim_next = 1'b1;
        end
      end
      SETTLE:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    claim_ack = (state_reg == ACK) && op_claim_reg;
    cmplt_ack = (state_reg == ACK) && !op_claim_reg;
  end

  // Entry just below the top becomes the new top after a pop.
  always_comb begin
    below_top = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_reg == 4'(i + 2)) below_top = mem_reg[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && sp_reg == 4'(i)) mem_reg[i] <= final_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg       <= 4'd0;
      top_reg      <= 8'd0;
      full_reg     <= 1'b0;
      rdata_reg    <= 8'd0;
      cmplt_id_reg <= 8'd0;
      err_reg      <= 1'b0;
    end else begin
      rdata_reg    <= do_push ? final_id : 8'd0;
      cmplt_id_reg <= do_pop ? bus.cmplt_wdata : 8'd0;
      err_reg      <= do_cmplt && !do_pop;
      if (do_push) begin
        sp_reg   <= sp_reg + 4'd1;
        top_reg  <= final_id;
        full_reg <= (sp_reg + 4'd1 == DEPTH_W);
      end else if (do_pop) begin
        sp_reg   <= sp_reg - 4'd1;
        top_reg  <= below_top;
        full_reg <= 1'b0;
      end
    end
  end

  // rdata is non-zero only in the ack cycle of a successful push.
  genvar gi;
  generate
    for (gi = 0; gi <= EXT_IRQ_NUM; gi++) begin : g_ip_clr
      if (gi == 0) begin : g_zero
        assign ip_clr[gi] = 1'b0;
      end else begin : g_id
        assign ip_clr[gi] = claim_ack && (rdata_reg == 8'(gi));
      end
    end
  endgenerate

  assign bus.claim_ack   = claim_ack;
  assign bus.claim_rdata = rdata_reg;
  assign bus.cmplt_ack   = cmplt_ack;
  assign bus.cmplt_err   = err_reg;
  assign claim_id        = top_reg;
  assign cmplt_id        = cmplt_id_reg;
  assign nest_level      = sp_reg;
  assign stack_full      = full_reg;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Self-checking bench for plic_claim_ctrl: vector table, corner sequences, random ops vs a LIFO model.
// Honours PLIC_CLAIM_NEST_EN the same way as the design (depth 4 vs 1).
module tb_plic_claim_ctrl;
  localparam int IRQ = 31;
`ifdef PLIC_CLAIM_NEST_EN
  localparam int DEP = 4;
`else
  localparam int DEP = 1;
`endif
  localparam bit NEST = (DEP > 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     final_id;
  logic           ext_irq;
  logic [7:0]     claim_id;
  logic [7:0]     cmplt_id;
  logic [IRQ:0]   ip_clr;
  logic [3:0]     nest_level;
  logic           stack_full;

  always #5 clk = ~clk;

  plic_claim_ctrl_if bus_if();

  plic_claim_ctrl #(.EXT_IRQ_NUM(IRQ), .NEST_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if.slave),
    .final_id   (final_id),
    .ext_irq    (ext_irq),
    .claim_id   (claim_id),
    .cmplt_id   (cmplt_id),
    .ip_clr     (ip_clr),
    .nest_level (nest_level),
    .stack_full (stack_full)
  );

  int n_checks = 0;
  int n_errors = 0;
  int q[$];

  typedef struct {
    bit         is_claim;
    logic [7:0] id;
    bit         irq;
    logic [7:0] e_val;
    bit         e_err;
    logic [7:0] e_top;
    int         e_lvl;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic run_claim(input logic [7:0] fid, input bit irq, input logic [7:0] e_rdata,
                           input logic [7:0] e_top, input int e_lvl, input string tag);
    logic [IRQ:0] e_clr;
    e_clr = '0;
    if (e_rdata != 8'd0) e_clr[e_rdata[4:0]] = 1'b1;
    final_id = fid;
    ext_irq = irq;
    bus_if.claim_req = 1'b1;
    tick;
    chk({tag, ".settle_ack"}, 64'(bus_if.claim_ack), 64'd0);
    chk({tag, ".settle_clr"}, 64'(ip_clr), 64'd0);
    tick;
    chk({tag, ".ack"}, 64'(bus_if.claim_ack), 64'd1);
    chk({tag, ".rdata"}, 64'(bus_if.claim_rdata), 64'(e_rdata));
    chk({tag, ".ip_clr"}, 64'(ip_clr), 64'(e_clr));
    chk({tag, ".claim_id"}, 64'(claim_id), 64'(e_top));
    chk({tag, ".nest_level"}, 64'(nest_level), 64'(e_lvl));
    chk({tag, ".stack_full"}, 64'(stack_full), 64'(e_lvl == DEP));
    $display("claim %s id=%0d irq=%0b -> rdata=%0d top=%0d lvl=%0d", tag, fid, irq,
             bus_if.claim_rdata, claim_id, nest_level);
    bus_if.claim_req = 1'b0;
    tick;
    chk({tag, ".ack_drop"}, 64'(bus_if.claim_ack), 64'd0);
    chk({tag, ".clr_drop"}, 64'(ip_clr), 64'd0);
  endtask

  task automatic run_cmplt(input logic [7:0] wd, input logic [7:0] e_id, input bit e_err,
                           input logic [7:0] e_top, input int e_lvl, input string tag);
    bus_if.cmplt_wdata = wd;
    bus_if.cmplt_req = 1'b1;
    tick;
    chk({tag, ".ack"}, 64'(bus_if.cmplt_ack), 64'd1);
    chk({tag, ".cmplt_id"}, 64'(cmplt_id), 64'(e_id));
    chk({tag, ".err"}, 64'(bus_if.cmplt_err), 64'(e_err));
    chk({tag, ".claim_id"}, 64'(claim_id), 64'(e_top));
    chk({tag, ".nest_level"}, 64'(nest_level), 64'(e_lvl));
    $display("cmplt %s id=%0d -> cmplt_id=%0d err=%0b top=%0d lvl=%0d", tag, wd, cmplt_id,
             bus_if.cmplt_err, claim_id, nest_level);
    bus_if.cmplt_req = 1'b0;
    tick;
    chk({tag, ".ack_drop"}, 64'(bus_if.cmplt_ack), 64'd0);
    chk({tag, ".id_drop"}, 64'(cmplt_id), 64'd0);
  endtask

  // Reference model: plain LIFO of IDs with the claim/complete rules.
  function automatic logic [7:0] m_top();
    return (q.size() == 0) ? 8'd0 : 8'(q[$]);
  endfunction

  function automatic logic [7:0] m_claim(input logic [7:0] fid, input bit irq);
    if (irq && fid != 0 && int'(fid) <= IRQ && q.size() < DEP) begin
      q.push_back(int'(fid));
      return fid;
    end
    return 8'd0;
  endfunction

  initial begin
    rst = 1'b1;
    final_id = 8'd0;
    ext_irq = 1'b0;
    bus_if.claim_req = 1'b0;
    bus_if.cmplt_req = 1'b0;
    bus_if.cmplt_wdata = 8'd0;

    tbl[0]  = '{1'b1, 8'd5,  1'b1, 8'd5, 1'b0, 8'd5, 1};
    tbl[1]  = '{1'b1, 8'd9,  1'b1, NEST ? 8'd9 : 8'd0, 1'b0, NEST ? 8'd9 : 8'd5, NEST ? 2 : 1};
    tbl[2]  = '{1'b0, 8'd9,  1'b0, NEST ? 8'd9 : 8'd0, !NEST, 8'd5, 1};
    tbl[3]  = '{1'b0, 8'd5,  1'b0, 8'd5, 1'b0, 8'd0, 0};
    tbl[4]  = '{1'b0, 8'd5,  1'b0, 8'd0, 1'b1, 8'd0, 0};
    tbl[5]  = '{1'b0, 8'd0,  1'b0, 8'd0, 1'b1, 8'd0, 0};
    tbl[6]  = '{1'b1, 8'd7,  1'b0, 8'd0, 1'b0, 8'd0, 0};
    tbl[7]  = '{1'b1, 8'd0,  1'b1, 8'd0, 1'b0, 8'd0, 0};
    tbl[8]  = '{1'b1, 8'd40, 1'b1, 8'd0, 1'b0, 8'd0, 0};
    tbl[9]  = '{1'b1, 8'd3,  1'b1, 8'd3, 1'b0, 8'd3, 1};
    tbl[10] = '{1'b1, 8'd7,  1'b1, NEST ? 8'd7 : 8'd0, 1'b0, NEST ? 8'd7 : 8'd3, NEST ? 2 : 1};
    tbl[11] = '{1'b0, 8'd3,  1'b0, NEST ? 8'd0 : 8'd3, NEST, NEST ? 8'd7 : 8'd0, NEST ? 2 : 0};

    tick;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("reset.claim_ack", 64'(bus_if.claim_ack), 64'd0);
    chk("reset.cmplt_ack", 64'(bus_if.cmplt_ack), 64'd0);
    chk("reset.rdata", 64'(bus_if.claim_rdata), 64'd0);
    chk("reset.err", 64'(bus_if.cmplt_err), 64'd0);
    chk("reset.claim_id", 64'(claim_id), 64'd0);
    chk("reset.cmplt_id", 64'(cmplt_id), 64'd0);
    chk("reset.ip_clr", 64'(ip_clr), 64'd0);
    chk("reset.nest_level", 64'(nest_level), 64'd0);
    chk("reset.stack_full", 64'(stack_full), 64'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_claim)
        run_claim(tbl[i].id, tbl[i].irq, tbl[i].e_val, tbl[i].e_top, tbl[i].e_lvl,
                  $sformatf("vec%0d", i));
      else
        run_cmplt(tbl[i].id, tbl[i].e_val, tbl[i].e_err, tbl[i].e_top, tbl[i].e_lvl,
                  $sformatf("vec%0d", i));
    end

    // Fill the stack, then one claim too many.
    do_reset;
    for (int i = 1; i <= DEP; i++)
      run_claim(8'(i), 1'b1, 8'(i), 8'(i), i, $sformatf("fill%0d", i));
    run_claim(8'd12, 1'b1, 8'd0, 8'(DEP), DEP, "overfill");
    run_cmplt(8'd12, 8'd0, 1'b1, 8'(DEP), DEP, "overfill_cmplt");

    // Claim and complete requested together: complete first, claim three cycles later.
    do_reset;
    run_claim(8'd5, 1'b1, 8'd5, 8'd5, 1, "both_pre");
    final_id = 8'd9;
    ext_irq = 1'b1;
    bus_if.cmplt_wdata = 8'd5;
    bus_if.cmplt_req = 1'b1;
    bus_if.claim_req = 1'b1;
    tick;
    chk("both.cmplt_ack", 64'(bus_if.cmplt_ack), 64'd1);
    chk("both.cmplt_id", 64'(cmplt_id), 64'd5);
    chk("both.claim_ack_n1", 64'(bus_if.claim_ack), 64'd0);
    chk("both.claim_id_n1", 64'(claim_id), 64'd0);
    bus_if.cmplt_req = 1'b0;
    tick;
    chk("both.claim_ack_n2", 64'(bus_if.claim_ack), 64'd0);
    tick;
    chk("both.claim_ack_n3", 64'(bus_if.claim_ack), 64'd0);
    tick;
    chk("both.claim_ack_n4", 64'(bus_if.claim_ack), 64'd1);
    chk("both.rdata", 64'(bus_if.claim_rdata), 64'd9);
    chk("both.claim_id_n4", 64'(claim_id), 64'd9);
    $display("both claim+cmplt: cmplt 5 then claim 9 top=%0d", claim_id);
    bus_if.claim_req = 1'b0;
    tick;

    // Reset while in SETTLE aborts the claim and empties the stack.
    do_reset;
    run_claim(8'd5, 1'b1, 8'd5, 8'd5, 1, "rst_pre");
    final_id = 8'd9;
    ext_irq = 1'b1;
    bus_if.claim_req = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    chk("rst_settle.claim_ack", 64'(bus_if.claim_ack), 64'd0);
    chk("rst_settle.claim_id", 64'(claim_id), 64'd0);
    chk("rst_settle.nest_level", 64'(nest_level), 64'd0);
    chk("rst_settle.ip_clr", 64'(ip_clr), 64'd0);
    chk("rst_settle.rdata", 64'(bus_if.claim_rdata), 64'd0);
    rst = 1'b0;
    bus_if.claim_req = 1'b0;
    tick;
    chk("rst_settle.ack_after", 64'(bus_if.claim_ack), 64'd0);
    chk("rst_settle.level_after", 64'(nest_level), 64'd0);
    $display("reset in SETTLE: top=%0d lvl=%0d", claim_id, nest_level);

    // Random claim/complete traffic against the LIFO model.
    do_reset;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        logic [7:0] fid;
        logic [7:0] e;
        bit irq;
        fid = 8'($urandom_range(0, 40));
        irq = ($urandom_range(0, 3) != 0);
        e = m_claim(fid, irq);
        run_claim(fid, irq, e, m_top(), q.size(), "rnd_claim");
      end else begin
        logic [7:0] wd;
        logic [7:0] e_id;
        bit e_err;
        if (q.size() > 0 && $urandom_range(0, 9) < 7) wd = 8'(q[$]);
        else wd = 8'($urandom_range(0, 31));
        if (q.size() > 0 && q[$] == int'(wd)) begin
          void'(q.pop_back());
          e_id = wd;
          e_err = 1'b0;
        end else begin
          e_id = 8'd0;
          e_err = 1'b1;
        end
        run_cmplt(wd, e_id, e_err, m_top(), q.size(), "rnd_cmplt");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
